dbus_arbiter: RTL and testbench

Two-master arbiter for the SoC data bus (address decoder, data memory, factorial unit, GPIO).
- Shares the bus between the MIPS core's memory-stage port (CPU) and a DMA requester.
- CPU has default priority. An anti-starvation counter forces DMA bursts of bounded length.
- Beats are held while the selected slave deasserts bus_rdy, and the CPU is stalled until its beat completes.

---
 rtl/dbus_arbiter.sv | 132 +++++++++++++
 tb/tb_dbus_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: the CPU memory stage has default priority, and the DMA gets bounded forced bursts.
// A beat that the selected slave stalls (bus_rdy_i low) is locked to its owner until it completes.
module dbus_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wd_i,
    output logic [DW-1:0] cpu_rd_o,
    output logic          cpu_stall_o,
    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wd_i,
    output logic [DW-1:0] dma_rd_o,
    output logic          dma_ack_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wd_o,
    input  logic [DW-1:0] bus_rd_i,
    input  logic          bus_rdy_i
);

    // state              | meaning
    // lock=0, forced=0   | free arbitration, CPU first
    // lock=0, forced=1   | DMA burst in progress, DMA first while it requests
    // lock=1, own=0      | CPU beat stalled by slave, held until bus_rdy_i
    // lock=1, own=1      | DMA beat stalled by slave, held until bus_rdy_i

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    logic          lock_q, lock_d;
    logic          lock_own_q, lock_own_d;
    logic          forced_q, forced_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;

    logic gnt_cpu, gnt_dma, gnt_any;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
            forced_q   <= 1'b0;
            starve_q   <= '0;
            burst_q    <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
            forced_q   <= forced_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
        end
    end

    always_comb begin
        lock_d     = gnt_any & ~bus_rdy_i;
        lock_own_d = lock_own_q;
        if (gnt_any && !bus_rdy_i) begin
            lock_own_d = gnt_dma;
        end

        starve_d = starve_q;
        if (!dma_req_i || dma_ack_o) begin
            starve_d = '0;
        end else if (!gnt_dma && !forced_q && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        forced_d = forced_q;
        burst_d  = burst_q;
        if (forced_q) begin
            // The burst ends on its last ack or as soon as the DMA stops asking.
            if (!dma_req_i || (dma_ack_o && burst_q == BURST_LAST)) begin
                forced_d = 1'b0;
                burst_d  = '0;
            end else if (dma_ack_o) begin
                burst_d = burst_q + 1'b1;
            end
        end else if (starve_d == STARVE_MAX) begin
            forced_d = 1'b1;
        end
    end

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_dma = 1'b0;
        if (!rst_i) begin
            if (lock_q) begin
                gnt_cpu = ~lock_own_q;
                gnt_dma = lock_own_q;
            end else if (forced_q && dma_req_i) begin
                gnt_dma = 1'b1;
            end else if (cpu_req_i) begin
                gnt_cpu = 1'b1;
            end else if (dma_req_i) begin
                gnt_dma = 1'b1;
            end
        end
        gnt_any = gnt_cpu | gnt_dma;

        bus_we_o   = 1'b0;
        bus_addr_o = '0;
        bus_wd_o   = '0;
        cpu_rd_o   = '0;
        dma_rd_o   = '0;
        if (gnt_cpu) begin
            bus_we_o   = cpu_we_i;
            bus_addr_o = cpu_addr_i;
            bus_wd_o   = cpu_wd_i;
            cpu_rd_o   = bus_rd_i;
        end else if (gnt_dma) begin
            bus_we_o   = dma_we_i;
            bus_addr_o = dma_addr_i;
            bus_wd_o   = dma_wd_i;
            dma_rd_o   = bus_rd_i;
        end

        cpu_stall_o = cpu_req_i & ~(gnt_cpu & bus_rdy_i);
        dma_ack_o   = gnt_dma & bus_rdy_i;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios with literal expectations, plus a rule-level model
// that is compared against the outputs on every cycle.
module tb_dbus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 8;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dma_req, dma_we, bus_rdy;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wd, dma_wd, bus_rd;
    logic [DW-1:0] cpu_rd, dma_rd, bus_wd;
    logic [AW-1:0] bus_addr;
    logic          cpu_stall, dma_ack, bus_we;

    always #5 clk = ~clk;

    dbus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .BURST_MAX(BM)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wd_i(cpu_wd),
        .cpu_rd_o(cpu_rd), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wd_i(dma_wd),
        .dma_rd_o(dma_rd), .dma_ack_o(dma_ack),
        .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wd_o(bus_wd),
        .bus_rd_i(bus_rd), .bus_rdy_i(bus_rdy)
    );

    int total = 0;
    int bad   = 0;

    // Model state: who holds a stalled beat (-1 nobody, 0 CPU, 1 DMA) and the fairness counters.
    int m_lock   = -1;
    int m_starve = 0;
    int m_burst  = 0;
    bit m_forced = 1'b0;

    // Literal expectation slot, filled by the stimulus and checked at the next falling edge.
    bit            lit_on = 1'b0;
    string         lit_tag;
    logic [AW-1:0] lit_addr;
    logic          lit_we, lit_stall, lit_ack;
    logic [DW-1:0] lit_crd, lit_drd;
    bit            is_dma;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int            g;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_crd, e_drd;
        logic          e_we, e_stall, e_ack;

        if (lit_on) begin
            chk({lit_tag, ".addr"},   bus_addr,  lit_addr);
            chk({lit_tag, ".we"},     bus_we,    lit_we);
            chk({lit_tag, ".stall"},  cpu_stall, lit_stall);
            chk({lit_tag, ".ack"},    dma_ack,   lit_ack);
            chk({lit_tag, ".cpu_rd"}, cpu_rd,    lit_crd);
            chk({lit_tag, ".dma_rd"}, dma_rd,    lit_drd);
        end

        g = -1;
        if (!rst) begin
            if (m_lock >= 0)              g = m_lock;
            else if (m_forced && dma_req) g = 1;
            else if (cpu_req)             g = 0;
            else if (dma_req)             g = 1;
        end
        e_addr  = (g == 0) ? cpu_addr : (g == 1) ? dma_addr : '0;
        e_wd    = (g == 0) ? cpu_wd   : (g == 1) ? dma_wd   : '0;
        e_we    = (g == 0) ? cpu_we   : (g == 1) ? dma_we   : 1'b0;
        e_crd   = (g == 0) ? bus_rd : '0;
        e_drd   = (g == 1) ? bus_rd : '0;
        e_stall = cpu_req && !(g == 0 && bus_rdy);
        e_ack   = (g == 1) && bus_rdy;

        chk("m.addr",   bus_addr,  e_addr);
        chk("m.wd",     bus_wd,    e_wd);
        chk("m.we",     bus_we,    e_we);
        chk("m.cpu_rd", cpu_rd,    e_crd);
        chk("m.dma_rd", dma_rd,    e_drd);
        chk("m.stall",  cpu_stall, e_stall);
        chk("m.ack",    dma_ack,   e_ack);

        if (rst) begin
            m_lock   = -1;
            m_starve = 0;
            m_burst  = 0;
            m_forced = 1'b0;
        end else begin
            m_lock = (g >= 0 && !bus_rdy) ? g : -1;
            if (!dma_req || e_ack)
                m_starve = 0;
            else if (g != 1 && !m_forced && m_starve < SL)
                m_starve++;
            if (m_forced) begin
                if (e_ack) m_burst++;
                if (!dma_req || m_burst == BM) begin
                    m_forced = 1'b0;
                    m_burst  = 0;
                end
            end else if (m_starve == SL) begin
                m_forced = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_on = 1'b0;
    endtask

    task automatic expect_lit(input string tag, input logic [AW-1:0] addr, input logic we,
                              input logic stall, input logic ack,
                              input logic [DW-1:0] crd, input logic [DW-1:0] drd);
        lit_tag   = tag;
        lit_addr  = addr;
        lit_we    = we;
        lit_stall = stall;
        lit_ack   = ack;
        lit_crd   = crd;
        lit_drd   = drd;
        lit_on    = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wd = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wd = '0;
        bus_rd = '0; bus_rdy = 1'b1;
        tick();

        // Reset with a CPU write pending, then release.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wd = 32'h55;
        expect_lit("t1_rst", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        expect_lit("t1_rel", 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // CPU-only read with a ready slave.
        tick();
        cpu_we = 1'b0; cpu_addr = 32'h04; bus_rd = 32'hDEADBEEF;
        expect_lit("t2_rd", 32'h04, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0);
        tick();
        cpu_req = 1'b0;
        expect_lit("t2_idle", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // DMA write held through three wait states; CPU arrives in cycle 2.
        tick();
        bus_rd = 32'hA5A5; bus_rdy = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h800; dma_wd = 32'h5;
        expect_lit("t3_c1", 32'h800, 1'b1, 1'b0, 1'b0, 32'h0, 32'hA5A5);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
        expect_lit("t3_c2", 32'h800, 1'b1, 1'b1, 1'b0, 32'h0, 32'hA5A5);
        tick();
        expect_lit("t3_c3", 32'h800, 1'b1, 1'b1, 1'b0, 32'h0, 32'hA5A5);
        tick();
        bus_rdy = 1'b1;
        expect_lit("t3_c4", 32'h800, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA5A5);
        tick();
        dma_req = 1'b0;
        expect_lit("t3_c5", 32'h20, 1'b0, 1'b0, 1'b0, 32'hA5A5, 32'h0);
        tick();
        cpu_req = 1'b0;
        expect_lit("t3_idle", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Both requesting: 8 CPU / 4 DMA rhythm, then a burst cut short by dma_req dropping.
        bus_rd = 32'h77;
        cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wd = 32'h11;
        dma_we = 1'b0; dma_addr = 32'h900; dma_wd = 32'h22;
        for (int k = 1; k <= 48; k++) begin
            tick();
            cpu_req = 1'b1;
            dma_req = (k != 35);
            is_dma = (k >= 9 && k <= 12) || (k >= 21 && k <= 24) || k == 33 || k == 34 ||
                     (k >= 44 && k <= 47);
            if (is_dma)
                expect_lit($sformatf("t45_c%0d", k), 32'h900, 1'b0, 1'b1, 1'b1, 32'h0, 32'h77);
            else
                expect_lit($sformatf("t45_c%0d", k), 32'h30, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0);
        end
        tick();
        cpu_req = 1'b0; dma_req = 1'b0;

        // Reset while a DMA write is locked.
        tick();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h804; dma_wd = 32'h9; bus_rdy = 1'b0;
        expect_lit("t6_lock", 32'h804, 1'b1, 1'b0, 1'b0, 32'h0, 32'h77);
        tick();
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        expect_lit("t6_rst", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0; bus_rdy = 1'b1;
        expect_lit("t6_after", 32'h40, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0);

        // Mixed traffic with wait states and the occasional reset, checked by the model only.
        for (int k = 0; k < 400; k++) begin
            tick();
            rst      = ($urandom_range(0, 99) == 0);
            cpu_req  = ($urandom_range(0, 99) < 80);
            dma_req  = ($urandom_range(0, 99) < 92);
            cpu_we   = $urandom_range(0, 1);
            dma_we   = $urandom_range(0, 1);
            cpu_addr = $urandom;
            dma_addr = $urandom;
            cpu_wd   = $urandom;
            dma_wd   = $urandom;
            bus_rd   = $urandom;
            bus_rdy  = ($urandom_range(0, 99) < 65);
        end
        tick();
        rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
